// File: rtl/rc4_phase_ctrl.sv
// RC4 decrypt sequencer: runs S-init, KSA and PRGA engines in turn,
// owns the S-memory write port and reports busy/done/err to the host.
module rc4_phase_ctrl #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 2048,
    parameter int TW      = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          eng_clr_n,
    output logic          init_start,
    output logic          ksa_start,
    output logic          prga_start,
    input  logic          init_done,
    input  logic          ksa_done,
    input  logic          prga_done,
    input  logic          init_wren,
    input  logic [AW-1:0] init_addr,
    input  logic [DW-1:0] init_data,
    input  logic          ksa_wren,
    input  logic [AW-1:0] ksa_addr,
    input  logic [DW-1:0] ksa_data,
    input  logic          prga_wren,
    input  logic [AW-1:0] prga_addr,
    input  logic [DW-1:0] prga_data,
    output logic          mem_wren,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR,
        S_INIT_GO,
        S_INIT_WAIT,
        S_KSA_GO,
        S_KSA_WAIT,
        S_PRGA_GO,
        S_PRGA_WAIT,
        S_FINISH,
        S_ERROR
    } state_t;

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        nxt;
    logic [TW-1:0] cnt;
    logic          in_run;
    logic          in_wait;
    logic          cur_done;
    logic          gate;
    logic          sel_wren;

    function automatic logic [2:0] phase_of(input state_t s);
        logic [2:0] p;
        p = 3'd0;
        unique case (s)
            S_CLR, S_INIT_GO, S_INIT_WAIT: p = 3'd1;
            S_KSA_GO, S_KSA_WAIT:          p = 3'd2;
            S_PRGA_GO, S_PRGA_WAIT:        p = 3'd3;
            S_FINISH:                      p = 3'd4;
            S_ERROR:                       p = 3'd7;
            default:                       p = 3'd0;
        endcase
        return p;
    endfunction

    assign in_run  = (state != S_IDLE) && (state != S_FINISH)
                  && (state != S_ERROR);
    assign in_wait = (state == S_INIT_WAIT) || (state == S_KSA_WAIT)
                  || (state == S_PRGA_WAIT);

    // Abort or a pending reset suppresses anything that touches memory or engines.
    assign gate = ~abort & rst_n;

    always_comb begin
        cur_done = 1'b0;
        unique case (state)
            S_INIT_WAIT: cur_done = init_done;
            S_KSA_WAIT:  cur_done = ksa_done;
            S_PRGA_WAIT: cur_done = prga_done;
            default:     cur_done = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:      if (start) nxt = S_CLR;
            S_CLR:       nxt = S_INIT_GO;
            S_INIT_GO:   nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (cur_done)         nxt = S_KSA_GO;
                else if (cnt == LAST) nxt = S_ERROR;
            end
            S_KSA_GO:    nxt = S_KSA_WAIT;
            S_KSA_WAIT:  begin
                if (cur_done)         nxt = S_PRGA_GO;
                else if (cnt == LAST) nxt = S_ERROR;
            end
            S_PRGA_GO:   nxt = S_PRGA_WAIT;
            S_PRGA_WAIT: begin
                if (cur_done)         nxt = S_FINISH;
                else if (cnt == LAST) nxt = S_ERROR;
            end
            S_FINISH,
            S_ERROR:     if (start) nxt = S_CLR;
            default:     nxt = S_IDLE;
        endcase
        if (abort && in_run) nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            phase     <= 3'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            eng_clr_n <= 1'b1;
        end else begin
            state     <= nxt;
            phase     <= phase_of(nxt);
            busy      <= (nxt != S_IDLE) && (nxt != S_FINISH)
                      && (nxt != S_ERROR);
            done      <= (nxt == S_FINISH);
            err       <= (nxt == S_ERROR);
            eng_clr_n <= (nxt != S_CLR);
            if (!in_wait)
                cnt <= '0;
            else if (!cur_done && cnt != LAST)
                cnt <= cnt + TW'(1);
        end
    end

    assign init_start = (state == S_INIT_GO) & gate;
    assign ksa_start  = (state == S_KSA_GO) & gate;
    assign prga_start = (state == S_PRGA_GO) & gate;

    always_comb begin
        sel_wren = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        unique case (state)
            S_INIT_GO, S_INIT_WAIT: begin
                sel_wren = init_wren;
                mem_addr = init_addr;
                mem_data = init_data;
            end
            S_KSA_GO, S_KSA_WAIT: begin
                sel_wren = ksa_wren;
                mem_addr = ksa_addr;
                mem_data = ksa_data;
            end
            S_PRGA_GO, S_PRGA_WAIT: begin
                sel_wren = prga_wren;
                mem_addr = prga_addr;
                mem_data = prga_data;
            end
            default: begin
                sel_wren = 1'b0;
                mem_addr = '0;
                mem_data = '0;
            end
        endcase
    end

    assign mem_wren = sel_wren & gate;

endmodule

// File: tb/tb_rc4_phase_ctrl.sv
// Bench for rc4_phase_ctrl: abstract run model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rc4_phase_ctrl;

    localparam int TIMEOUT = 2048;

    logic       clk = 1'b0;
    logic       rst_n, start, abort;
    logic       eng_clr_n, init_start, ksa_start, prga_start;
    logic       init_done, ksa_done, prga_done;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] init_addr, init_data, ksa_addr, ksa_data;
    logic [7:0] prga_addr, prga_data;
    logic       mem_wren;
    logic [7:0] mem_addr, mem_data;
    logic [2:0] phase;
    logic       busy, done, err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit en = 0;
    int n_clr = 0, n_init = 0, n_ksa = 0, n_prga = 0;
    int s_clr, s_init, s_ksa, s_prga;

    rc4_phase_ctrl #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT), .TW(12)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .eng_clr_n(eng_clr_n), .init_start(init_start),
        .ksa_start(ksa_start), .prga_start(prga_start),
        .init_done(init_done), .ksa_done(ksa_done), .prga_done(prga_done),
        .init_wren(init_wren), .init_addr(init_addr), .init_data(init_data),
        .ksa_wren(ksa_wren), .ksa_addr(ksa_addr), .ksa_data(ksa_data),
        .prga_wren(prga_wren), .prga_addr(prga_addr), .prga_data(prga_data),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
        .phase(phase), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Abstract model: run mode, which engine is active, cycles spent waiting.
    localparam int MI = 0, MC = 1, MG = 2, MW = 3, MF = 4, ME = 5;
    int m_mode = MI;
    int m_eng = 0;
    int m_wait = 0;

    always @(posedge clk) begin
        logic dn;
        bit   run;
        cyc++;
        dn  = (m_eng == 0) ? init_done : (m_eng == 1) ? ksa_done : prga_done;
        run = (m_mode == MC) || (m_mode == MG) || (m_mode == MW);
        if (!rst_n) begin
            m_mode = MI;
            m_wait = 0;
        end else if (abort && run) begin
            m_mode = MI;
        end else begin
            case (m_mode)
                MI, MF, ME: if (start) m_mode = MC;
                MC: begin m_mode = MG; m_eng = 0; end
                MG: begin m_mode = MW; m_wait = 0; end
                MW: begin
                    if (dn) begin
                        if (m_eng == 2) m_mode = MF;
                        else begin m_eng++; m_mode = MG; end
                    end else if (m_wait + 1 >= TIMEOUT) begin
                        m_mode = ME;
                    end else begin
                        m_wait++;
                    end
                end
                default: m_mode = MI;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [2:0] e_ph;
        logic       act, g, e_w;
        logic [7:0] e_a, e_d;
        logic       rw[3];
        logic [7:0] ra[3], rd[3];
        if (en) begin
            rw[0] = init_wren; ra[0] = init_addr; rd[0] = init_data;
            rw[1] = ksa_wren;  ra[1] = ksa_addr;  rd[1] = ksa_data;
            rw[2] = prga_wren; ra[2] = prga_addr; rd[2] = prga_data;
            case (m_mode)
                MC:      e_ph = 3'd1;
                MG, MW:  e_ph = 3'(m_eng + 1);
                MF:      e_ph = 3'd4;
                ME:      e_ph = 3'd7;
                default: e_ph = 3'd0;
            endcase
            act = (m_mode == MG) || (m_mode == MW);
            g   = !abort && rst_n;
            e_w = act ? (rw[m_eng] && g) : 1'b0;
            e_a = act ? ra[m_eng] : 8'h00;
            e_d = act ? rd[m_eng] : 8'h00;
            chk("m_phase", 32'(phase), 32'(e_ph));
            chk("m_busy", 32'(busy),
                32'((m_mode == MC) || (m_mode == MG) || (m_mode == MW)));
            chk("m_done", 32'(done), 32'(m_mode == MF));
            chk("m_err", 32'(err), 32'(m_mode == ME));
            chk("m_clr_n", 32'(eng_clr_n), 32'(m_mode != MC));
            chk("m_init_start", 32'(init_start),
                32'(m_mode == MG && m_eng == 0 && g));
            chk("m_ksa_start", 32'(ksa_start),
                32'(m_mode == MG && m_eng == 1 && g));
            chk("m_prga_start", 32'(prga_start),
                32'(m_mode == MG && m_eng == 2 && g));
            chk("m_wren", 32'(mem_wren), 32'(e_w));
            chk("m_addr", 32'(mem_addr), 32'(e_a));
            chk("m_data", 32'(mem_data), 32'(e_d));
            if (!eng_clr_n) n_clr++;
            if (init_start) n_init++;
            if (ksa_start)  n_ksa++;
            if (prga_start) n_prga++;
        end
    end

    initial begin
        rst_n = 0; start = 0; abort = 0;
        init_done = 0; ksa_done = 0; prga_done = 0;
        init_wren = 0; ksa_wren = 0; prga_wren = 0;
        init_addr = 8'h00; init_data = 8'h00;
        ksa_addr = 8'h00;  ksa_data = 8'h00;
        prga_addr = 8'h00; prga_data = 8'h00;
        step(2);
        en = 1;
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_clr_n", 32'(eng_clr_n), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Idle: no engine reaches memory
        init_wren = 1; ksa_wren = 1; prga_wren = 1;
        init_addr = 8'h12; ksa_addr = 8'h34; prga_addr = 8'h56;
        #1;
        chk("idle_wren", 32'(mem_wren), 32'd0);
        chk("idle_addr", 32'(mem_addr), 32'd0);
        init_wren = 0; ksa_wren = 0; prga_wren = 0;
        rst_n = 1;
        step(1);

        // Normal run
        s_clr = n_clr; s_init = n_init; s_ksa = n_ksa; s_prga = n_prga;
        start = 1; step(1); start = 0;
        chk("run_clr", 32'(eng_clr_n), 32'd0);
        chk("run_busy", 32'(busy), 32'd1);
        step(1);
        chk("run_init_start", 32'(init_start), 32'd1);
        chk("run_phase1", 32'(phase), 32'd1);
        step(1);
        step(258); init_done = 1; step(1);
        chk("run_ksa_start", 32'(ksa_start), 32'd1);
        chk("run_phase2", 32'(phase), 32'd2);
        step(1);
        init_wren = 1; init_addr = 8'h55; init_data = 8'h11;
        ksa_wren = 1; ksa_addr = 8'hA3; ksa_data = 8'h7E;
        prga_wren = 1; prga_addr = 8'h33; prga_data = 8'h22;
        #1;
        chk("mux_addr", 32'(mem_addr), 32'hA3);
        chk("mux_data", 32'(mem_data), 32'h7E);
        chk("mux_wren", 32'(mem_wren), 32'd1);
        ksa_wren = 0; #1;
        chk("mux_wren_off", 32'(mem_wren), 32'd0);
        step(797); ksa_done = 1; step(1);
        chk("run_prga_start", 32'(prga_start), 32'd1);
        chk("run_phase3", 32'(phase), 32'd3);
        chk("run_prga_addr", 32'(mem_addr), 32'h33);
        step(1);
        step(98); prga_done = 1; step(1);
        chk("run_done", 32'(done), 32'd1);
        chk("run_phase4", 32'(phase), 32'd4);
        chk("run_busy_end", 32'(busy), 32'd0);
        chk("run_n_clr", 32'(n_clr - s_clr), 32'd1);
        chk("run_n_init", 32'(n_init - s_init), 32'd1);
        chk("run_n_ksa", 32'(n_ksa - s_ksa), 32'd1);
        chk("run_n_prga", 32'(n_prga - s_prga), 32'd1);
        step(3);
        chk("fin_hold", 32'(phase), 32'd4);
        abort = 1; step(1); abort = 0;
        chk("fin_abort", 32'(done), 32'd1);

        // Timeout in KSA
        init_done = 0; ksa_done = 0; prga_done = 0;
        init_wren = 0; prga_wren = 0;
        start = 1; step(1); start = 0;
        step(2);
        init_done = 1; step(1); init_done = 0;
        step(1);
        ksa_wren = 1; ksa_addr = 8'h0F;
        step(TIMEOUT - 1);
        chk("to_before", 32'(err), 32'd0);
        step(1);
        chk("to_err", 32'(err), 32'd1);
        chk("to_phase", 32'(phase), 32'd7);
        chk("to_wren", 32'(mem_wren), 32'd0);
        step(2);
        chk("to_hold", 32'(err), 32'd1);
        ksa_wren = 0;
        start = 1; step(1); start = 0;
        chk("to_restart_err", 32'(err), 32'd0);
        chk("to_restart_busy", 32'(busy), 32'd1);

        // Done and timeout in the same cycle
        step(2);
        step(TIMEOUT - 1);
        init_done = 1; step(1);
        chk("col_phase", 32'(phase), 32'd2);
        chk("col_ksa_start", 32'(ksa_start), 32'd1);
        chk("col_err", 32'(err), 32'd0);

        // Abort in PRGA_WAIT
        step(1); ksa_done = 1; step(2);
        prga_wren = 1; prga_addr = 8'h44; prga_data = 8'h99; #1;
        chk("ab_wren_pre", 32'(mem_wren), 32'd1);
        s_prga = n_prga;
        abort = 1; #1;
        chk("ab_wren", 32'(mem_wren), 32'd0);
        step(1); abort = 0;
        chk("ab_phase", 32'(phase), 32'd0);
        chk("ab_n_prga", 32'(n_prga - s_prga), 32'd0);

        // Stale init_done across restart
        start = 1; step(1); start = 0;
        chk("st_clr", 32'(eng_clr_n), 32'd0);
        init_done = 0; ksa_done = 0; prga_done = 0;
        step(1);
        chk("st_init_start", 32'(init_start), 32'd1);
        step(6);
        chk("st_wait", 32'(phase), 32'd1);
        s_clr = n_clr;
        start = 1; step(1); start = 0;
        step(2);
        chk("busy_start_ign", 32'(n_clr - s_clr), 32'd0);
        chk("busy_start_ph", 32'(phase), 32'd1);

        // Reset mid-run in KSA_WAIT
        init_done = 1; step(1); init_done = 0;
        step(4);
        ksa_wren = 1; ksa_addr = 8'hC0;
        rst_n = 0; #1;
        chk("rr_wren", 32'(mem_wren), 32'd0);
        step(1); rst_n = 1;
        chk("rr_phase", 32'(phase), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_clr_n", 32'(eng_clr_n), 32'd1);
        ksa_wren = 0;

        // Abort in INIT_GO suppresses the start pulse
        start = 1; step(1); start = 0;
        step(1);
        abort = 1; #1;
        chk("ab_go_start", 32'(init_start), 32'd0);
        step(1); abort = 0;
        chk("ab_go_phase", 32'(phase), 32'd0);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
